spi_pkt_word_parser: RTL and testbench

// - Parses the 32-bit word stream delivered by the SPI slave (rx_data/rx_data_valid) into framed packets.
// - Frame: SYNC, ADDR, LEN, {ID,TYPE}, HDR_CHK, ceil(LEN/4) data words, DATA_CHK.
// - Emits the header fields, a data-word stream, and start/end/error pulses to the downstream sink.

---
 rtl/spi_pkt_pkg.sv | 42 ++++
 rtl/spi_pkt_word_parser.sv | 159 +++++++++++++++
 tb/tb_spi_pkt_word_parser.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkt_pkg.sv
// Shared definitions for the SPI packet word parser: frame marker, length
// limit, FSM state encoding and header checksum helpers.
package spi_pkt_pkg;

    localparam logic [31:0] SYNC_WORD     = 32'h5A5A_A5A5;
    localparam logic [31:0] MAX_LEN_BYTES = 32'd4096;

    // Position of each header word within a frame.
    localparam logic [2:0] HDR_IDX_SYNC   = 3'd0;
    localparam logic [2:0] HDR_IDX_ADDR   = 3'd1;
    localparam logic [2:0] HDR_IDX_LEN    = 3'd2;
    localparam logic [2:0] HDR_IDX_IDTYPE = 3'd3;
    localparam logic [2:0] HDR_IDX_HCHK   = 3'd4;

    // Parser states; header states reuse the index of the word they expect.
    typedef logic [2:0] state_t;
    localparam state_t ST_HUNT   = HDR_IDX_SYNC;
    localparam state_t ST_ADDR   = HDR_IDX_ADDR;
    localparam state_t ST_LEN    = HDR_IDX_LEN;
    localparam state_t ST_IDTYPE = HDR_IDX_IDTYPE;
    localparam state_t ST_HCHK   = HDR_IDX_HCHK;
    localparam state_t ST_DATA   = 3'd5;
    localparam state_t ST_DCHK   = 3'd6;

    // Expected header check word: plain 32-bit XOR of the four header words.
    function automatic logic [31:0] hdr_check(
        input logic [31:0] sync_w,
        input logic [31:0] addr_w,
        input logic [31:0] len_w,
        input logic [31:0] idtype_w
    );
        return sync_w ^ addr_w ^ len_w ^ idtype_w;
    endfunction

    // Number of payload words for a byte length: ceil(len/4), 31 bits.
    function automatic logic [30:0] data_word_count(input logic [31:0] len_bytes);
        logic [32:0] sum;
        sum = {1'b0, len_bytes} + 33'd3;
        return sum[32:2];
    endfunction

endpackage

// File: rtl/spi_pkt_word_parser.sv
// Frames the 32-bit SPI word stream into packets: hunts for the sync word,
// captures and checks the header, streams the payload and checks the data XOR.
// All outputs are registered one clock after the word that causes them.
module spi_pkt_word_parser
    import spi_pkt_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rx_data,
    input  logic        rx_data_valid,
    input  logic        pkt_rx_enable,
    output logic [31:0] pkt_rx_addr,
    output logic [31:0] pkt_rx_length,
    output logic [15:0] pkt_rx_id,
    output logic [15:0] pkt_rx_type,
    output logic [31:0] pkt_rx_data,
    output logic        pkt_rx_data_valid,
    output logic        pkg_rx_start,
    output logic        pkg_rx_end,
    output logic        error
);

    state_t      state_r;
    logic [31:0] addr_sh_r;
    logic [31:0] len_sh_r;
    logic [31:0] idtype_sh_r;
    logic [30:0] word_cnt_r;
    logic [31:0] data_xor_r;

    logic        advance_s;
    logic        hdr_ok_s;

    assign advance_s = rx_data_valid & pkt_rx_enable;
    assign hdr_ok_s  = (rx_data == hdr_check(SYNC_WORD, addr_sh_r, len_sh_r, idtype_sh_r)) &&
                       (len_sh_r <= MAX_LEN_BYTES);

    // Frame sequencing: state, header shadows, payload word counter and data XOR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_HUNT;
            addr_sh_r   <= 32'd0;
            len_sh_r    <= 32'd0;
            idtype_sh_r <= 32'd0;
            word_cnt_r  <= 31'd0;
            data_xor_r  <= 32'd0;
        end else if (!pkt_rx_enable) begin
            // Disabling abandons any frame in progress silently.
            state_r    <= ST_HUNT;
            word_cnt_r <= 31'd0;
            data_xor_r <= 32'd0;
        end else if (rx_data_valid) begin
            case (state_r)
                ST_HUNT: begin
                    if (rx_data == SYNC_WORD) begin
                        state_r <= ST_ADDR;
                    end else begin
                        state_r <= ST_HUNT;
                    end
                end
                ST_ADDR: begin
                    addr_sh_r <= rx_data;
                    state_r   <= ST_LEN;
                end
                ST_LEN: begin
                    len_sh_r <= rx_data;
                    state_r  <= ST_IDTYPE;
                end
                ST_IDTYPE: begin
                    idtype_sh_r <= rx_data;
                    state_r     <= ST_HCHK;
                end
                ST_HCHK: begin
                    data_xor_r <= 32'd0;
                    if (!hdr_ok_s) begin
                        state_r    <= ST_HUNT;
                        word_cnt_r <= 31'd0;
                    end else if (len_sh_r == 32'd0) begin
                        state_r    <= ST_DCHK;
                        word_cnt_r <= 31'd0;
                    end else begin
                        state_r    <= ST_DATA;
                        word_cnt_r <= data_word_count(len_sh_r);
                    end
                end
                ST_DATA: begin
                    // A sync pattern here is ordinary payload.
                    data_xor_r <= data_xor_r ^ rx_data;
                    word_cnt_r <= word_cnt_r - 31'd1;
                    if (word_cnt_r == 31'd1) begin
                        state_r <= ST_DCHK;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                ST_DCHK: begin
                    state_r    <= ST_HUNT;
                    word_cnt_r <= 31'd0;
                    data_xor_r <= 32'd0;
                end
                default: begin
                    state_r    <= ST_HUNT;
                    word_cnt_r <= 31'd0;
                    data_xor_r <= 32'd0;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    // Registered outputs: header publish, payload stream and one-clock pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_rx_addr       <= 32'd0;
            pkt_rx_length     <= 32'd0;
            pkt_rx_id         <= 16'd0;
            pkt_rx_type       <= 16'd0;
            pkt_rx_data       <= 32'd0;
            pkt_rx_data_valid <= 1'b0;
            pkg_rx_start      <= 1'b0;
            pkg_rx_end        <= 1'b0;
            error             <= 1'b0;
        end else begin
            pkt_rx_data_valid <= 1'b0;
            pkg_rx_start      <= 1'b0;
            pkg_rx_end        <= 1'b0;
            error             <= 1'b0;
            if (advance_s) begin
                case (state_r)
                    ST_HCHK: begin
                        if (hdr_ok_s) begin
                            pkt_rx_addr   <= addr_sh_r;
                            pkt_rx_length <= len_sh_r;
                            pkt_rx_id     <= idtype_sh_r[31:16];
                            pkt_rx_type   <= idtype_sh_r[15:0];
                            pkg_rx_start  <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        pkt_rx_data       <= rx_data;
                        pkt_rx_data_valid <= 1'b1;
                    end
                    ST_DCHK: begin
                        pkg_rx_end <= 1'b1;
                        error      <= (rx_data != data_xor_r);
                    end
                    default: begin
                        pkg_rx_end <= 1'b0;
                    end
                endcase
            end else begin
                pkg_rx_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_pkt_word_parser.sv
// Randomised self-checking bench for spi_pkt_word_parser. A frame-level
// reference model predicts every output one clock after each input word.
module tb_spi_pkt_word_parser;

    localparam logic [31:0] TB_SYNC = 32'h5A5A_A5A5;
    localparam logic [31:0] TB_MAX  = 32'd4096;

    logic        clk;
    logic        rst_n;
    logic [31:0] rx_data;
    logic        rx_data_valid;
    logic        pkt_rx_enable;
    logic [31:0] pkt_rx_addr;
    logic [31:0] pkt_rx_length;
    logic [15:0] pkt_rx_id;
    logic [15:0] pkt_rx_type;
    logic [31:0] pkt_rx_data;
    logic        pkt_rx_data_valid;
    logic        pkg_rx_start;
    logic        pkg_rx_end;
    logic        error;

    spi_pkt_word_parser dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rx_data           (rx_data),
        .rx_data_valid     (rx_data_valid),
        .pkt_rx_enable     (pkt_rx_enable),
        .pkt_rx_addr       (pkt_rx_addr),
        .pkt_rx_length     (pkt_rx_length),
        .pkt_rx_id         (pkt_rx_id),
        .pkt_rx_type       (pkt_rx_type),
        .pkt_rx_data       (pkt_rx_data),
        .pkt_rx_data_valid (pkt_rx_data_valid),
        .pkg_rx_start      (pkg_rx_start),
        .pkg_rx_end        (pkg_rx_end),
        .error             (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus table: one entry per clock.
    logic [31:0] stim_w[$];
    logic        stim_v[$];
    logic        stim_en[$];
    logic        rand_gaps = 1'b0;

    // Reference model: collected header words, remaining payload words, running XOR.
    logic [31:0] m_words[$];
    int          m_rem;
    logic        m_body;
    logic [31:0] m_xor;
    logic [31:0] e_addr, e_len, e_data;
    logic [15:0] e_id, e_type;
    logic        e_dv, e_start, e_end, e_err;

    // Pulse tallies observed on the DUT.
    int c_start, c_dv, c_end, c_err, c_end_err;

    task automatic model_reset();
        m_words.delete();
        m_rem = 0; m_body = 1'b0; m_xor = 32'd0;
        e_addr = 32'd0; e_len = 32'd0; e_id = 16'd0; e_type = 16'd0; e_data = 32'd0;
        e_dv = 1'b0; e_start = 1'b0; e_end = 1'b0; e_err = 1'b0;
    endtask

    task automatic model_cycle(input logic v, input logic en, input logic [31:0] w);
        e_dv = 1'b0; e_start = 1'b0; e_end = 1'b0; e_err = 1'b0;
        if (!en) begin
            m_words.delete(); m_body = 1'b0; m_rem = 0; m_xor = 32'd0;
        end else if (v) begin
            if (m_body) begin
                if (m_rem > 0) begin
                    e_data = w; e_dv = 1'b1; m_xor ^= w; m_rem--;
                end else begin
                    e_end = 1'b1; e_err = (w != m_xor);
                    m_body = 1'b0; m_words.delete();
                end
            end else if (m_words.size() == 0) begin
                if (w == TB_SYNC) m_words.push_back(w);
            end else begin
                m_words.push_back(w);
                if (m_words.size() == 5) begin
                    if (w == (m_words[0] ^ m_words[1] ^ m_words[2] ^ m_words[3]) && m_words[2] <= TB_MAX) begin
                        e_addr = m_words[1]; e_len = m_words[2];
                        e_id = m_words[3][31:16]; e_type = m_words[3][15:0];
                        e_start = 1'b1;
                        m_rem = int'((m_words[2] + 32'd3) / 32'd4);
                        m_body = 1'b1; m_xor = 32'd0;
                    end else begin
                        e_err = 1'b1; m_words.delete();
                    end
                end
            end
        end
    endtask

    task automatic clear_counts();
        c_start = 0; c_dv = 0; c_end = 0; c_err = 0; c_end_err = 0;
    endtask

    // Drive one clock of stimulus; returns observed and predicted output vectors.
    task automatic drive_cycle(input logic v, input logic en, input logic [31:0] w,
                               output logic [131:0] got, output logic [131:0] exp);
        @(negedge clk);
        rx_data = w; rx_data_valid = v; pkt_rx_enable = en;
        model_cycle(v, en, w);
        @(posedge clk);
        #1;
        got = {pkt_rx_addr, pkt_rx_length, pkt_rx_id, pkt_rx_type, pkt_rx_data,
               pkt_rx_data_valid, pkg_rx_start, pkg_rx_end, error};
        exp = {e_addr, e_len, e_id, e_type, e_data, e_dv, e_start, e_end, e_err};
        c_dv += int'(pkt_rx_data_valid);
        c_start += int'(pkg_rx_start);
        c_end += int'(pkg_rx_end);
        c_err += int'(error);
        c_end_err += int'(pkg_rx_end & error);
    endtask

    task automatic stim_clear();
        stim_w.delete(); stim_v.delete(); stim_en.delete();
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            stim_w.push_back($urandom); stim_v.push_back(1'b0); stim_en.push_back(1'b1);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        if (rand_gaps && $urandom_range(0, 3) == 0) push_idle(1);
        stim_w.push_back(w); stim_v.push_back(1'b1); stim_en.push_back(1'b1);
    endtask

    // mode 0: payload 1,2,3..; mode 1: random; mode 2: every word is the sync pattern.
    task automatic push_frame(input logic [31:0] addr, input logic [31:0] len, input logic [31:0] idtype,
                              input logic [31:0] hflip, input logic [31:0] dflip, input int mode);
        logic [31:0] x, d;
        int n;
        push_word(TB_SYNC); push_word(addr); push_word(len); push_word(idtype);
        push_word(TB_SYNC ^ addr ^ len ^ idtype ^ hflip);
        if (len <= TB_MAX) begin
            n = int'((len + 32'd3) / 32'd4);
            x = 32'd0;
            for (int i = 0; i < n; i++) begin
                d = (mode == 0) ? 32'(i + 1) : (mode == 1) ? 32'($urandom) : TB_SYNC;
                push_word(d);
                x ^= d;
            end
            push_word(x ^ dflip);
        end
    endtask

    task automatic push_nominal();
        push_frame(32'hABCD_0000, 32'd16, 32'h1234_002A, 32'd0, 32'd0, 0);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({pkt_rx_addr, pkt_rx_length, pkt_rx_id, pkt_rx_type, pkt_rx_data,
             pkt_rx_data_valid, pkg_rx_start, pkg_rx_end, error} !== 132'd0)
            begin errors++; $display("FAIL reset_state got addr=%h len=%h data=%h pulses=%b%b%b%b want all 0",
                pkt_rx_addr, pkt_rx_length, pkt_rx_data, pkt_rx_data_valid, pkg_rx_start, pkg_rx_end, error); end
        @(negedge clk);
        rst_n = 1'b1; pkt_rx_enable = 1'b1;
    endtask

    task automatic test_nominal();
        logic [131:0] got, exp;
        stim_clear(); clear_counts();
        push_nominal(); push_idle(2);
        for (int i = 0; i < stim_w.size(); i++) begin
            drive_cycle(stim_v[i], stim_en[i], stim_w[i], got, exp);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL nominal cyc%0d got=%h want=%h", i, got, exp); end
        end
        checks++;
        if (c_start != 1 || c_dv != 4 || c_end != 1 || c_err != 0) begin errors++;
            $display("FAIL nominal_counts got s=%0d d=%0d e=%0d err=%0d want 1 4 1 0", c_start, c_dv, c_end, c_err); end
        checks++;
        if ({pkt_rx_addr, pkt_rx_length, pkt_rx_id, pkt_rx_type, pkt_rx_data} !==
            {32'hABCD_0000, 32'd16, 16'h1234, 16'h002A, 32'd4}) begin errors++;
            $display("FAIL nominal_hdr got %h %h %h %h %h want ABCD0000 00000010 1234 002A 00000004",
                pkt_rx_addr, pkt_rx_length, pkt_rx_id, pkt_rx_type, pkt_rx_data); end
    endtask

    task automatic test_garbage();
        logic [131:0] got, exp;
        stim_clear(); clear_counts();
        push_word(32'hDEAD_BEEF); push_word(32'd0); push_nominal(); push_idle(1);
        for (int i = 0; i < stim_w.size(); i++) begin
            drive_cycle(stim_v[i], stim_en[i], stim_w[i], got, exp);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL garbage cyc%0d got=%h want=%h", i, got, exp); end
        end
        checks++;
        if (c_start != 1 || c_dv != 4 || c_end != 1 || c_err != 0) begin errors++;
            $display("FAIL garbage_counts got s=%0d d=%0d e=%0d err=%0d want 1 4 1 0", c_start, c_dv, c_end, c_err); end
    endtask

    task automatic test_bad_hchk();
        logic [131:0] got, exp;
        stim_clear(); clear_counts();
        push_frame(32'h0BAD_0000, 32'd16, 32'h5555_0001, 32'd1, 32'd0, 0);
        push_nominal(); push_idle(1);
        for (int i = 0; i < stim_w.size(); i++) begin
            drive_cycle(stim_v[i], stim_en[i], stim_w[i], got, exp);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL bad_hchk cyc%0d got=%h want=%h", i, got, exp); end
        end
        checks++;
        if (c_start != 1 || c_dv != 4 || c_end != 1 || c_err != 1) begin errors++;
            $display("FAIL bad_hchk_counts got s=%0d d=%0d e=%0d err=%0d want 1 4 1 1", c_start, c_dv, c_end, c_err); end
    endtask

    task automatic test_bad_dchk();
        logic [131:0] got, exp;
        stim_clear(); clear_counts();
        push_frame(32'hABCD_0000, 32'd16, 32'h1234_002A, 32'd0, 32'd1, 0); push_idle(1);
        for (int i = 0; i < stim_w.size(); i++) begin
            drive_cycle(stim_v[i], stim_en[i], stim_w[i], got, exp);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL bad_dchk cyc%0d got=%h want=%h", i, got, exp); end
        end
        checks++;
        if (c_dv != 4 || c_end_err != 1 || c_err != 1) begin errors++;
            $display("FAIL bad_dchk_counts got d=%0d end&err=%0d err=%0d want 4 1 1", c_dv, c_end_err, c_err); end
    endtask

    task automatic test_short_lengths();
        logic [131:0] got, exp;
        stim_clear(); clear_counts();
        push_frame(32'h1000_0000, 32'd0, 32'h0001_0002, 32'd0, 32'd0, 1);
        push_frame(32'h2000_0000, 32'd5, 32'h0003_0004, 32'd0, 32'd0, 1); push_idle(1);
        for (int i = 0; i < stim_w.size(); i++) begin
            drive_cycle(stim_v[i], stim_en[i], stim_w[i], got, exp);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL short_len cyc%0d got=%h want=%h", i, got, exp); end
        end
        checks++;
        if (c_start != 2 || c_dv != 2 || c_end != 2 || c_err != 0) begin errors++;
            $display("FAIL short_len_counts got s=%0d d=%0d e=%0d err=%0d want 2 2 2 0", c_start, c_dv, c_end, c_err); end
    endtask

    task automatic test_len_boundary();
        logic [131:0] got, exp;
        stim_clear(); clear_counts();
        push_frame(32'h3000_0000, 32'd4097, 32'h0007_0008, 32'd0, 32'd0, 1);
        push_frame(32'h4000_0000, 32'd4096, 32'h0009_000A, 32'd0, 32'd0, 1); push_idle(1);
        for (int i = 0; i < stim_w.size(); i++) begin
            drive_cycle(stim_v[i], stim_en[i], stim_w[i], got, exp);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL len_bound cyc%0d got=%h want=%h", i, got, exp); end
        end
        checks++;
        if (c_start != 1 || c_dv != 1024 || c_end != 1 || c_err != 1) begin errors++;
            $display("FAIL len_bound_counts got s=%0d d=%0d e=%0d err=%0d want 1 1024 1 1", c_start, c_dv, c_end, c_err); end
    endtask

    task automatic test_enable_drop();
        logic [131:0] got, exp;
        stim_clear(); clear_counts();
        push_nominal();
        stim_en[7] = 1'b0;
        push_idle(1); push_nominal(); push_idle(1);
        for (int i = 0; i < stim_w.size(); i++) begin
            drive_cycle(stim_v[i], stim_en[i], stim_w[i], got, exp);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL en_drop cyc%0d got=%h want=%h", i, got, exp); end
        end
        checks++;
        if (c_start != 2 || c_dv != 6 || c_end != 1 || c_err != 0) begin errors++;
            $display("FAIL en_drop_counts got s=%0d d=%0d e=%0d err=%0d want 2 6 1 0", c_start, c_dv, c_end, c_err); end
    endtask

    task automatic test_back_to_back();
        logic [131:0] got, exp;
        stim_clear(); clear_counts();
        push_nominal();
        push_frame(32'h5000_0000, 32'd12, 32'hBEEF_0001, 32'd0, 32'd0, 2);
        push_nominal(); push_idle(1);
        for (int i = 0; i < stim_w.size(); i++) begin
            drive_cycle(stim_v[i], stim_en[i], stim_w[i], got, exp);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL b2b cyc%0d got=%h want=%h", i, got, exp); end
        end
        checks++;
        if (c_start != 3 || c_dv != 11 || c_end != 3 || c_err != 0) begin errors++;
            $display("FAIL b2b_counts got s=%0d d=%0d e=%0d err=%0d want 3 11 3 0", c_start, c_dv, c_end, c_err); end
    endtask

    task automatic test_random();
        logic [131:0] got, exp;
        int s;
        logic [31:0] len, hf, df;
        stim_clear(); clear_counts();
        rand_gaps = 1'b1;
        for (int f = 0; f < 40; f++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) push_word($urandom);
            len = ($urandom_range(0, 9) == 0) ? 32'(4097 + $urandom_range(0, 100)) : 32'($urandom_range(0, 40));
            hf = ($urandom_range(0, 7) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
            df = ($urandom_range(0, 7) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
            s = stim_w.size();
            push_frame($urandom, len, $urandom, hf, df, ($urandom_range(0, 9) == 0) ? 2 : 1);
            if ($urandom_range(0, 7) == 0) stim_en[$urandom_range(s, stim_w.size() - 1)] = 1'b0;
            push_idle($urandom_range(0, 2));
        end
        rand_gaps = 1'b0;
        for (int i = 0; i < stim_w.size(); i++) begin
            drive_cycle(stim_v[i], stim_en[i], stim_w[i], got, exp);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL random cyc%0d got=%h want=%h", i, got, exp); end
        end
    endtask

    task automatic test_async_reset();
        logic [131:0] got, exp;
        stim_clear(); clear_counts();
        push_nominal();
        for (int i = 0; i < 7; i++) begin
            drive_cycle(stim_v[i], stim_en[i], stim_w[i], got, exp);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL arst_pre cyc%0d got=%h want=%h", i, got, exp); end
        end
        #2;
        rst_n = 1'b0; rx_data_valid = 1'b0;
        #1;
        checks++;
        if ({pkt_rx_addr, pkt_rx_length, pkt_rx_id, pkt_rx_type, pkt_rx_data,
             pkt_rx_data_valid, pkg_rx_start, pkg_rx_end, error} !== 132'd0)
            begin errors++; $display("FAIL arst_outputs got addr=%h len=%h data=%h want all 0",
                pkt_rx_addr, pkt_rx_length, pkt_rx_data); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        stim_clear(); clear_counts();
        push_nominal(); push_idle(1);
        for (int i = 0; i < stim_w.size(); i++) begin
            drive_cycle(stim_v[i], stim_en[i], stim_w[i], got, exp);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL arst_post cyc%0d got=%h want=%h", i, got, exp); end
        end
        checks++;
        if (c_start != 1 || c_dv != 4 || c_end != 1 || c_err != 0) begin errors++;
            $display("FAIL arst_counts got s=%0d d=%0d e=%0d err=%0d want 1 4 1 0", c_start, c_dv, c_end, c_err); end
    endtask

    initial begin
        rst_n = 1'b0; rx_data = 32'd0; rx_data_valid = 1'b0; pkt_rx_enable = 1'b0;
        model_reset();
        test_reset();
        test_nominal();
        test_garbage();
        test_bad_hchk();
        test_bad_dchk();
        test_short_lengths();
        test_len_boundary();
        test_enable_drop();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
